// File: rtl/uart_rx_deser_if.sv
// Byte-side handshake and status bundle of the UART receiver.
// master: the receiver (drives byte, valid and status); slave: the consumer.
interface uart_rx_deser_if;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       parity_err_o;
    logic       overrun_o;
    logic       busy_o;

    modport master (
        output data_o,
        output valid_o,
        input  ready_i,
        output frame_err_o,
        output parity_err_o,
        output overrun_o,
        output busy_o
    );

    modport slave (
        input  data_o,
        input  valid_o,
        output ready_i,
        input  frame_err_o,
        input  parity_err_o,
        input  overrun_o,
        input  busy_o
    );
endinterface

// File: rtl/uart_rx_deser.sv
// UART receiver: 8 data bits, optional parity, 1 or 2 stop bits, mid-bit sampling
// driven by a runtime clocks-per-bit divisor. Delivers bytes on a valid/ready
// handshake and reports framing, parity and overrun errors as 1-cycle pulses.
module uart_rx_deser #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 pen_i,
    input  logic                 podd_i,
    input  logic                 stop2_i,
    input  logic                 rx_i,
    uart_rx_deser_if.master      rx_if
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop1  = 3'd4;
    localparam logic [2:0] StStop2  = 3'd5;
    localparam logic [2:0] StWaitHi = 3'd6;

    localparam logic [DIV_WIDTH-1:0] DivMin = DIV_WIDTH'(4);
    localparam logic [DIV_WIDTH-1:0] One    = DIV_WIDTH'(1);

    logic                 rx_meta_q, rx_sync_q;
    logic [2:0]           state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 pen_q, pen_d;
    logic                 podd_q, podd_d;
    logic                 stop2_q, stop2_d;
    logic [7:0]           shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_pulse_q, frame_pulse_d;
    logic                 parity_pulse_q, parity_pulse_d;
    logic                 overrun_pulse_q, overrun_pulse_d;

    logic                 rx_s;
    logic [DIV_WIDTH-1:0] half;
    logic [DIV_WIDTH-1:0] half_m1;
    logic [DIV_WIDTH-1:0] div_m1;
    logic                 complete;
    logic                 frame_bad;

    assign rx_s    = rx_sync_q;
    assign half    = div_q >> 1;
    assign half_m1 = half - One;
    assign div_m1  = div_q - One;

    // Next-state logic: bit timing, frame decode and completion handling.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q + One;
        idx_d           = idx_q;
        div_d           = div_q;
        pen_d           = pen_q;
        podd_d          = podd_q;
        stop2_d         = stop2_q;
        shift_d         = shift_q;
        par_err_d       = par_err_q;
        frm_err_d       = frm_err_q;
        data_d          = data_q;
        valid_d         = valid_q & ~rx_if.ready_i;
        frame_pulse_d   = 1'b0;
        parity_pulse_d  = 1'b0;
        overrun_pulse_d = 1'b0;
        complete        = 1'b0;
        frame_bad       = 1'b0;

        if (!en_i) begin
            // Disable abandons any frame in flight; the output byte is kept.
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        div_d     = (div_i < DivMin) ? DivMin : div_i;
                        pen_d     = pen_i;
                        podd_d    = podd_i;
                        stop2_d   = stop2_i;
                        par_err_d = 1'b0;
                        frm_err_d = 1'b0;
                        state_d   = StStart;
                    end
                end
                StStart: begin
                    if (cnt_q == half_m1) begin
                        cnt_d = '0;
                        idx_d = 3'd0;
                        // Line back high at mid-start means a glitch, not a frame.
                        state_d = rx_s ? StIdle : StData;
                    end
                end
                StData: begin
                    if (cnt_q == div_m1) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[7:1]};
                        idx_d   = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_d = pen_q ? StParity : StStop1;
                        end
                    end
                end
                StParity: begin
                    if (cnt_q == div_m1) begin
                        cnt_d     = '0;
                        par_err_d = rx_s != (^shift_q ^ podd_q);
                        state_d   = StStop1;
                    end
                end
                StStop1: begin
                    if (cnt_q == div_m1) begin
                        cnt_d = '0;
                        if (stop2_q) begin
                            frm_err_d = ~rx_s;
                            state_d   = StStop2;
                        end else begin
                            frame_bad = ~rx_s;
                            complete  = 1'b1;
                        end
                    end
                end
                StStop2: begin
                    if (cnt_q == div_m1) begin
                        cnt_d     = '0;
                        frame_bad = frm_err_q | ~rx_s;
                        complete  = 1'b1;
                    end
                end
                StWaitHi: begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            endcase

            // Completion happens at mid-stop so a back-to-back start bit is caught.
            if (complete) begin
                if (frame_bad) begin
                    frame_pulse_d = 1'b1;
                    state_d       = StWaitHi;
                end else if (par_err_q) begin
                    parity_pulse_d = 1'b1;
                    state_d        = StIdle;
                end else if (valid_q && !rx_if.ready_i) begin
                    overrun_pulse_d = 1'b1;
                    state_d         = StIdle;
                end else begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    state_d = StIdle;
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rx_meta_q       <= 1'b1;
            rx_sync_q       <= 1'b1;
            state_q         <= StIdle;
            cnt_q           <= '0;
            idx_q           <= 3'd0;
            div_q           <= '0;
            pen_q           <= 1'b0;
            podd_q          <= 1'b0;
            stop2_q         <= 1'b0;
            shift_q         <= 8'h00;
            par_err_q       <= 1'b0;
            frm_err_q       <= 1'b0;
            data_q          <= 8'h00;
            valid_q         <= 1'b0;
            frame_pulse_q   <= 1'b0;
            parity_pulse_q  <= 1'b0;
            overrun_pulse_q <= 1'b0;
        end else begin
            rx_meta_q       <= rx_i;
            rx_sync_q       <= rx_meta_q;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            div_q           <= div_d;
            pen_q           <= pen_d;
            podd_q          <= podd_d;
            stop2_q         <= stop2_d;
            shift_q         <= shift_d;
            par_err_q       <= par_err_d;
            frm_err_q       <= frm_err_d;
            data_q          <= data_d;
            valid_q         <= valid_d;
            frame_pulse_q   <= frame_pulse_d;
            parity_pulse_q  <= parity_pulse_d;
            overrun_pulse_q <= overrun_pulse_d;
        end
    end

    // Outputs are driven straight from registers.
    always_comb begin
        rx_if.data_o       = data_q;
        rx_if.valid_o      = valid_q;
        rx_if.frame_err_o  = frame_pulse_q;
        rx_if.parity_err_o = parity_pulse_q;
        rx_if.overrun_o    = overrun_pulse_q;
        rx_if.busy_o       = (state_q != StIdle);
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: bit-banged frames on rx_i, byte and
// error-pulse capture at the negative clock edge, hand-computed expectations.
module tb_uart_rx_deser;

    localparam int Div = 16;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        en_i = 1'b1;
    logic [15:0] div_i = 16'(Div);
    logic        pen_i = 1'b0;
    logic        podd_i = 1'b0;
    logic        stop2_i = 1'b0;
    logic        rx_i = 1'b1;

    uart_rx_deser_if u_if ();

    uart_rx_deser #(
        .DIV_WIDTH(16)
    ) u_dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (en_i),
        .div_i   (div_i),
        .pen_i   (pen_i),
        .podd_i  (podd_i),
        .stop2_i (stop2_i),
        .rx_i    (rx_i),
        .rx_if   (u_if)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Capture of delivered bytes and error pulses.
    logic [7:0] got_q[$];
    int frame_cnt = 0;
    int parity_cnt = 0;
    int overrun_cnt = 0;

    always @(negedge clk_i) begin
        if (u_if.valid_o && u_if.ready_i) got_q.push_back(u_if.data_o);
        if (u_if.frame_err_o) frame_cnt <= frame_cnt + 1;
        if (u_if.parity_err_o) parity_cnt <= parity_cnt + 1;
        if (u_if.overrun_o) overrun_cnt <= overrun_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx_i = v;
        repeat (Div) @(negedge clk_i);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_on, input logic par_bit,
                              input logic stop_bit, input logic two_stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (par_on) drive_bit(par_bit);
        drive_bit(stop_bit);
        if (two_stop) drive_bit(stop_bit);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (u_if.busy_o && n < 4000) begin
            @(negedge clk_i);
            n++;
        end
        check_eq("idle_reached", 32'(u_if.busy_o), 32'd0);
        repeat (4) @(negedge clk_i);
    endtask

    int q0, f0, p0, o0;

    task automatic snap();
        q0 = got_q.size();
        f0 = frame_cnt;
        p0 = parity_cnt;
        o0 = overrun_cnt;
    endtask

    initial begin
        u_if.ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        // Reset values
        check_eq("rst_data", 32'(u_if.data_o), 32'h00);
        check_eq("rst_valid", 32'(u_if.valid_o), 32'd0);
        check_eq("rst_busy", 32'(u_if.busy_o), 32'd0);
        check_eq("rst_errs", 32'({u_if.frame_err_o, u_if.parity_err_o, u_if.overrun_o}), 32'd0);
        rst_n_i = 1'b1;
        repeat (4) @(negedge clk_i);

        // Single byte, no parity, one stop
        snap();
        send_frame(8'h41, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_idle();
        check_eq("single_count", 32'(got_q.size() - q0), 32'd1);
        if (got_q.size() > q0) check_eq("single_data", 32'(got_q[q0]), 32'h41);
        check_eq("single_errs", 32'(frame_cnt + parity_cnt + overrun_cnt - f0 - p0 - o0), 32'd0);

        // Back-to-back frames, no idle gap
        snap();
        for (int k = 0; k < 10; k++) send_frame(8'(8'h41 + k), 1'b0, 1'b0, 1'b1, 1'b0);
        wait_idle();
        check_eq("b2b_count", 32'(got_q.size() - q0), 32'd10);
        for (int k = 0; k < 10; k++) begin
            if (got_q.size() > q0 + k) check_eq("b2b_data", 32'(got_q[q0 + k]), 32'(8'h41 + k));
        end

        // Even parity: 0x41 has two ones so parity bit 0 is correct
        pen_i  = 1'b1;
        podd_i = 1'b0;
        snap();
        send_frame(8'h41, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_idle();
        check_eq("par_ok_count", 32'(got_q.size() - q0), 32'd1);
        if (got_q.size() > q0) check_eq("par_ok_data", 32'(got_q[q0]), 32'h41);
        check_eq("par_ok_perr", 32'(parity_cnt - p0), 32'd0);
        snap();
        send_frame(8'h41, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_idle();
        check_eq("par_bad_perr", 32'(parity_cnt - p0), 32'd1);
        check_eq("par_bad_count", 32'(got_q.size() - q0), 32'd0);
        check_eq("par_bad_valid", 32'(u_if.valid_o), 32'd0);
        pen_i = 1'b0;

        // Two stop bits
        stop2_i = 1'b1;
        snap();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_idle();
        check_eq("stop2_count", 32'(got_q.size() - q0), 32'd1);
        if (got_q.size() > q0) check_eq("stop2_data", 32'(got_q[q0]), 32'h5A);
        stop2_i = 1'b0;

        // Framing error with line held low, then recovery
        snap();
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (40) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (2 * Div) @(negedge clk_i);
        check_eq("frm_ferr", 32'(frame_cnt - f0), 32'd1);
        check_eq("frm_count", 32'(got_q.size() - q0), 32'd0);
        check_eq("frm_busy", 32'(u_if.busy_o), 32'd0);
        snap();
        send_frame(8'h33, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_idle();
        check_eq("frm_next_count", 32'(got_q.size() - q0), 32'd1);
        if (got_q.size() > q0) check_eq("frm_next_data", 32'(got_q[q0]), 32'h33);

        // Overrun: consumer stalled across two frames
        u_if.ready_i = 1'b0;
        snap();
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_idle();
        check_eq("ovr_valid", 32'(u_if.valid_o), 32'd1);
        check_eq("ovr_data", 32'(u_if.data_o), 32'h11);
        check_eq("ovr_pulse", 32'(overrun_cnt - o0), 32'd1);
        u_if.ready_i = 1'b1;
        repeat (4) @(negedge clk_i);
        check_eq("ovr_drain_count", 32'(got_q.size() - q0), 32'd1);
        if (got_q.size() > q0) check_eq("ovr_drain_data", 32'(got_q[q0]), 32'h11);
        check_eq("ovr_drain_valid", 32'(u_if.valid_o), 32'd0);

        // 5-cycle glitch is a false start
        snap();
        rx_i = 1'b0;
        repeat (5) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (30) @(negedge clk_i);
        check_eq("glitch_busy", 32'(u_if.busy_o), 32'd0);
        check_eq("glitch_count", 32'(got_q.size() - q0), 32'd0);
        check_eq("glitch_errs", 32'(frame_cnt + parity_cnt + overrun_cnt - f0 - p0 - o0), 32'd0);

        // Reset in the middle of data bit 3 of 0xA5 (bits 1,0,1,0,...)
        snap();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx_i = 1'b0;
        repeat (Div / 2) @(negedge clk_i);
        check_eq("mid_busy_before", 32'(u_if.busy_o), 32'd1);
        rst_n_i = 1'b0;
        rx_i    = 1'b1;
        @(negedge clk_i);
        check_eq("mid_rst_data", 32'(u_if.data_o), 32'h00);
        check_eq("mid_rst_valid", 32'(u_if.valid_o), 32'd0);
        check_eq("mid_rst_busy", 32'(u_if.busy_o), 32'd0);
        rst_n_i = 1'b1;
        repeat (3 * Div) @(negedge clk_i);
        check_eq("mid_rst_nout", 32'(got_q.size() - q0), 32'd0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_idle();
        check_eq("mid_next_count", 32'(got_q.size() - q0), 32'd1);
        if (got_q.size() > q0) check_eq("mid_next_data", 32'(got_q[q0]), 32'hA5);
        check_eq("mid_next_errs", 32'(frame_cnt + parity_cnt + overrun_cnt - f0 - p0 - o0),
                 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_deser.md
# uart_rx_deser

Synthesizable asynchronous-serial receiver that deserializes an 8-bit UART frame stream from a single line into bytes. It provides a valid/ready output and per-frame error pulses. It sits at the far end of the UART transmit path: it takes `uart_tx_o` of `apb4_uart` in system-level checking setups, and any other RS232-style line. Bit timing comes from a runtime clocks-per-bit divisor; sampling is mid-bit.

## Interface
- `DIV_WIDTH`, 16: width of the divisor input.
- `clk_i`  in  1  system clock; all logic on rising edge.
- `rst_n_i`  in  1  reset; synchronous, active-low.
- `en_i`  in  1  receiver enable; low forces IDLE.
- `div_i`  in  DIV_WIDTH  clocks per bit. Values < 4 are treated as 4. Sampled only in IDLE.
- `pen_i`  in  1  parity bit present.
- `podd_i`  in  1  1 = odd parity, 0 = even parity.
- `stop2_i`  in  1  two stop bits expected.
- `rx_i`  in  1  serial line, asynchronous, idle high.
- `data_o`  out  8  received byte.
- `valid_o`  out  1  `data_o` holds an unread byte.
- `ready_i`  in  1  consumer accepts the byte when `valid_o & ready_i`.
- `frame_err_o`  out  1  1-cycle pulse: a stop bit was sampled low.
- `parity_err_o`  out  1  1-cycle pulse: parity mismatch.
- `overrun_o`  out  1  1-cycle pulse: a byte completed while `valid_o` was held.
- `busy_o`  out  1  FSM not in IDLE.

## Operation
- **Synchronizer:** 2-flop chain on `rx_i`; both flops reset to 1. Its output is `rx_s`.
- **Bit counter:** `cnt` (DIV_WIDTH) and bit index `idx` (3 bits). `div` is latched on leaving IDLE; `half = div >> 1`.
- **FSM states:** IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HI.
  - **IDLE:** if `en_i` and `rx_s == 0`, latch `div_i`/`pen_i`/`podd_i`/`stop2_i`, clear `cnt`, go to START.
  - **START:** sample when `cnt == half-1`. If `rx_s == 1`, it is a false start: go to IDLE with no output. Otherwise clear `cnt` and go to DATA with `idx = 0`.
  - **DATA:** sample at `cnt == div-1`. Shift into the shift register LSB first and increment `idx`. After bit 7, go to PARITY if `pen`, else STOP1.
  - **PARITY:** sample at `cnt == div-1`. Expected bit is `^data ^ podd`. Record mismatch; go to STOP1.
  - **STOP1:** sample at `cnt == div-1`. Low means frame error. If `stop2`, go to STOP2; else complete.
  - **STOP2:** same check as STOP1, then complete.
  - **Completion:**
    - Any frame error: discard the byte, pulse `frame_err_o`, go to WAIT_HI.
    - Else parity error: discard the byte, pulse `parity_err_o`, go to IDLE.
    - Else if `valid_o == 1` and no `ready_i` that cycle: keep the old byte, pulse `overrun_o`, go to IDLE.
    - Else: load `data_o`, set `valid_o`, go to IDLE.
  - **WAIT_HI:** stay until `rx_s == 1`, then go to IDLE. This prevents re-triggering on a break or stuck-low line.
- **Output handshake:** `valid_o` clears on `valid_o & ready_i`. A completion in the same cycle as acceptance loads the new byte and keeps `valid_o = 1`, with no overrun. `data_o` is stable while `valid_o = 1`.
- **Disable:** `en_i` low in any state forces IDLE next cycle and abandons the frame silently. `valid_o`/`data_o` are kept.
- **Configuration:** `div_i`, `pen_i`, `podd_i`, `stop2_i` changes while `busy_o` are ignored until the next IDLE.

## Timing
- **Reset values:** `data_o = 8'h00`, `valid_o = 0`, all error pulses 0, `busy_o = 0`, FSM IDLE, synchronizer flops 1, counters 0.
- **Start detection:** a falling edge on `rx_i` reaches `rx_s` 2 cycles later. IDLE→START on the next edge.
- **Sample points:** start sample `half` cycles after entering START. Each later sample exactly `div` cycles after the previous one.
- **Completion latency:** `valid_o` and error pulses assert the cycle after the last stop sample, i.e. about 2 + `half` + `div`·(8 + pen + 1 + stop2) cycles after the start edge.
- **Back-to-back frames:** the receiver returns to IDLE at mid-stop, so it accepts a new start bit with zero idle time.
- **Error pulses:** exactly one cycle; at most one of the three asserts per frame.
- **Mid-frame reset:** `rst_n_i` low mid-frame returns all state to reset values on that edge. A partial frame produces no output.

## Test plan
- `div_i = 16`, no parity, 1 stop; send 0x41, `ready_i = 1` → one `valid_o` pulse with `data_o = 0x41`, no error pulses.
- Send 0x41..0x4A back-to-back (no idle gap), `ready_i = 1` → 10 bytes delivered in order with values 0x41..0x4A.
- `pen_i = 1`, `podd_i = 0`; send 0x41 with correct parity (0) → byte delivered. Send 0x41 with parity = 1 → `parity_err_o` pulse, `valid_o` stays 0.
- Send 0x55 with stop bit forced low, line held low 40 cycles, then high → one `frame_err_o` pulse, no byte. Next frame 0x33 is delivered correctly.
- `ready_i = 0`; send 0x11 then 0x22 → `valid_o = 1` with `data_o = 0x11`, `overrun_o` pulse at the 0x22 completion. Raising `ready_i` yields only 0x11.
- 5-cycle low glitch on `rx_i` with `div_i = 16` → false start, no output, `busy_o` back to 0. Separately, assert `rst_n_i` low at data bit 3 → all outputs at reset values, and the next full frame 0xA5 decodes correctly.
